// File: rtl/game_controller_n.sv
`default_nettype none
// ============================================================================
// Module      : game_controller_n
// Description : Top-level sequencer for a sliding-tile (2048-style) game.
//               Samples and edge-detects the four move buttons on a slow tick
//               and issues one-hot move commands to the board engine. It also
//               requests new tiles from the generator and detects win or
//               no-move conditions.
//
// Ports
//   clk, rst       : clock, synchronous active-low reset
//   button_press   : raw move buttons {3,2,1,0}
//   board_state    : N*N cell codes, cell 0 in the LSBs
//   movable        : bit1 = dirs 3/1 legal, bit0 = dirs 2/0 legal
//   board_done     : per-direction move-complete from the board engine
//   gen_done/loc/low : tile generator handshake, free cell, small-tile choice
//   move_dir       : one-cycle one-hot move command
//   preset*        : tile insert strobe, location and code
//   block_exist    : occupied-cell map
//   state          : current FSM state
//   won            : win flag
//   clear_board    : one-cycle board clear pulse (auto-restart builds only)
//
// Build option
//   GAME_AUTO_RESTART_EN : when defined, a button edge in ENDED or WON
//                          restarts the game; otherwise both are terminal.
//
// Revision    : 1.0 - initial release
// ============================================================================
module game_controller_n #(
    parameter int N        = 4,
    parameter int CELL_W   = 4,
    parameter int TICK_DIV = 650000,
    parameter int WIN_CODE = 11,
    parameter int PEND_MAX = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             button_press,
    input  logic [N*N*CELL_W-1:0]  board_state,
    input  logic [1:0]             movable,
    input  logic [3:0]             board_done,
    input  logic                   gen_done,
    input  logic [$clog2(N*N)-1:0] gen_loc,
    input  logic                   gen_low,
    output logic [3:0]             move_dir,
    output logic                   preset,
    output logic [$clog2(N*N)-1:0] preset_loc,
    output logic [CELL_W-1:0]      preset_val,
    output logic [N*N-1:0]         block_exist,
    output logic [3:0]             state,
    output logic                   won,
    output logic                   clear_board
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_IDLE       = 4'd0;
    localparam logic [3:0] c_INIT_1     = 4'd1;
    localparam logic [3:0] c_PEND_INIT  = 4'd2;
    localparam logic [3:0] c_INIT_2     = 4'd3;
    localparam logic [3:0] c_WAIT_PRESS = 4'd4;
    localparam logic [3:0] c_PENDING    = 4'd5;
    localparam logic [3:0] c_CHECK      = 4'd6;
    localparam logic [3:0] c_ENDED      = 4'd7;
    localparam logic [3:0] c_WON        = 4'd8;

    // +2 keeps the widths at least one bit even for degenerate limits of 0
    localparam int c_TICK_W = $clog2(TICK_DIV + 2);
    localparam int c_WD_W   = $clog2(PEND_MAX + 2);

    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICK_DIV);
    localparam logic [c_WD_W-1:0]   c_WD_MAX   = c_WD_W'(PEND_MAX);
    localparam logic [31:0]         c_WIN_CODE = 32'(WIN_CODE);
    localparam logic [CELL_W-1:0]   c_VAL_LOW  = CELL_W'(1);
    localparam logic [CELL_W-1:0]   c_VAL_HIGH = CELL_W'(2);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [3:0]          r_state;
    logic [3:0]          w_state_nx;
    logic [c_TICK_W-1:0] r_tick;
    logic [3:0]          r_s1;
    logic [3:0]          r_s2;
    logic [3:0]          r_move_dir;
    logic [3:0]          r_sent;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_won;

    logic                w_slot;
    logic [3:0]          w_rise;
    logic [3:0]          w_gate;
    logic [3:0]          w_cand;
    logic [3:0]          w_onehot;
    logic                w_win;
    logic                w_restart;

    // ------------------------------------------------------------------------
    // Occupied-cell map
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N*N; gi++) begin : g_cells
            assign block_exist[gi] = |board_state[gi*CELL_W +: CELL_W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Win detection: any cell at or above the winning code
    // ------------------------------------------------------------------------
    always_comb begin
        w_win = 1'b0;
        for (int i = 0; i < N*N; i++) begin
            if (32'(board_state[i*CELL_W +: CELL_W]) >= c_WIN_CODE) begin
                w_win = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Button edge detection and move selection
    // ------------------------------------------------------------------------
    // Buttons are sampled at the end of each tick period, so a rising edge is
    // evaluated once per period, in the slot where the counter is at zero.
    assign w_slot = (r_tick == '0);
    assign w_rise = r_s1 & ~r_s2;

    // Vertical directions (3/1) and horizontal directions (2/0) share a
    // legality bit each.
    assign w_gate = {movable[1], movable[0], movable[1], movable[0]};

    // Holding off while a pulse is already out keeps the pulse to a single
    // cycle even if the tick period degenerates to one clock.
    assign w_cand = (r_state == c_WAIT_PRESS && w_slot && r_move_dir == 4'b0000)
                    ? (w_rise & w_gate) : 4'b0000;

    // Highest-numbered direction wins a simultaneous press
    always_comb begin
        w_onehot = 4'b0000;
        if (w_cand[3]) begin
            w_onehot = 4'b1000;
        end else if (w_cand[2]) begin
            w_onehot = 4'b0100;
        end else if (w_cand[1]) begin
            w_onehot = 4'b0010;
        end else if (w_cand[0]) begin
            w_onehot = 4'b0001;
        end
    end

    // ------------------------------------------------------------------------
    // Optional auto-restart
    // ------------------------------------------------------------------------
`ifdef GAME_AUTO_RESTART_EN
    logic r_clear_board;

    // Any direction restarts; legality of the move is irrelevant here
    assign w_restart = (r_state == c_ENDED || r_state == c_WON) && w_slot && (|w_rise);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clear_board <= 1'b0;
        end else begin
            r_clear_board <= w_restart;
        end
    end

    assign clear_board = r_clear_board;
`else
    assign w_restart   = 1'b0;
    assign clear_board = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE: begin
                w_state_nx = c_INIT_1;
            end
            c_INIT_1: begin
                if (gen_done) begin
                    w_state_nx = c_PEND_INIT;
                end
            end
            c_PEND_INIT: begin
                w_state_nx = c_INIT_2;
            end
            c_INIT_2: begin
                if (gen_done) begin
                    w_state_nx = c_CHECK;
                end else if (movable == 2'b00) begin
                    w_state_nx = c_ENDED;
                end
            end
            c_WAIT_PRESS: begin
                if (|r_move_dir) begin
                    w_state_nx = c_PENDING;
                end
            end
            c_PENDING: begin
                if (movable == 2'b00) begin
                    w_state_nx = c_ENDED;
                end else if (|(r_sent & board_done)) begin
                    w_state_nx = c_INIT_2;
                end else if (r_wd == c_WD_MAX) begin
                    w_state_nx = c_CHECK;
                end
            end
            c_CHECK: begin
                if (w_win) begin
                    w_state_nx = c_WON;
                end else if (movable == 2'b00) begin
                    w_state_nx = c_ENDED;
                end else begin
                    w_state_nx = c_WAIT_PRESS;
                end
            end
            c_ENDED, c_WON: begin
                if (w_restart) begin
                    w_state_nx = c_IDLE;
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_tick     <= '0;
            r_s1       <= 4'b0000;
            r_s2       <= 4'b0000;
            r_move_dir <= 4'b0000;
            r_sent     <= 4'b0000;
            r_wd       <= '0;
            r_won      <= 1'b0;
        end else begin
            r_state <= w_state_nx;

            if (r_tick == c_TICK_MAX) begin
                r_tick <= '0;
                r_s1   <= button_press;
                r_s2   <= r_s1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end

            r_move_dir <= w_onehot;

            // Remember which direction is outstanding so only its completion
            // flag advances the game.
            if (|w_onehot) begin
                r_sent <= w_onehot;
            end else if (w_state_nx == c_INIT_2 && r_state != c_INIT_2) begin
                r_sent <= 4'b0000;
            end

            // Held at zero outside PENDING, so every entry starts a fresh count
            if (r_state != c_PENDING) begin
                r_wd <= '0;
            end else if (r_wd != c_WD_MAX) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_restart) begin
                r_won <= 1'b0;
            end else if (r_state == c_WON) begin
                r_won <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign move_dir   = r_move_dir;
    assign state      = r_state;
    assign won        = r_won;
    assign preset     = gen_done && (r_state == c_INIT_1 || r_state == c_INIT_2);
    assign preset_loc = gen_done ? gen_loc : '0;
    assign preset_val = gen_low ? c_VAL_LOW : c_VAL_HIGH;

endmodule
`default_nettype wire

// File: doc/game_controller_n.md
GAME_CONTROLLER_N -- requirements
Module: game_controller_n

Interface
REQ-001 SHALL have parameters: N, default 4, board side length; CELL_W, default 4, log2 tile code width; TICK_DIV, default 650000, button sample period in clk cycles; WIN_CODE, default 11, tile code that wins (2^11 = 2048); PEND_MAX, default 1023, PENDING watchdog limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, clock; rst, in, 1, reset (synchronous, active-low).
REQ-003 SHALL have ports: button_press, in, 4, raw buttons {3,2,1,0}; board_state, in, N*N*CELL_W, cell codes with cell 0 in the LSBs.
REQ-004 SHALL have ports: movable, in, 2, bit1 = dirs 3/1 legal, bit0 = dirs 2/0 legal; board_done, in, 4, per-direction move-complete; gen_done, in, 1, generator has a location; gen_loc, in, clog2(N*N), free cell index; gen_low, in, 1, generator chose the small tile.
REQ-005 SHALL have ports: move_dir, out, 4, one-hot move command pulse; preset, out, 1, insert-tile strobe; preset_loc, out, clog2(N*N), insert location; preset_val, out, CELL_W, insert code.
REQ-006 SHALL have ports: block_exist, out, N*N, occupied-cell map; state, out, 4, FSM state; won, out, 1, win flag; clear_board, out, 1, board clear pulse.

Function
REQ-007 SHALL drive block_exist[i] = 1 when cell i code is nonzero (combinational).
REQ-008 SHALL run a tick counter 0..TICK_DIV, wrapping to 0 after TICK_DIV; sample stage s1 <= button_press and s2 <= s1 at count TICK_DIV.
REQ-009 SHALL, at count 0 in WAIT_PRESS only, set candidate bit d when s1[d]=1, s2[d]=0 and movable gates it (dirs 3/1: movable[1]; dirs 2/0: movable[0]).
REQ-010 SHALL reduce simultaneous candidates to one-hot, highest index wins, and pulse move_dir for exactly one cycle; move_dir is 0 at all other times.
REQ-011 SHALL latch the issued direction in a sent register, cleared on entry to INIT_2.
REQ-012 SHALL implement states IDLE=0, INIT_1=1, PEND_INIT=2, INIT_2=3, WAIT_PRESS=4, PENDING=5, CHECK=6, ENDED=7, WON=8.
REQ-013 SHALL transition: IDLE->INIT_1 unconditionally; INIT_1->PEND_INIT on preset; PEND_INIT->INIT_2; INIT_2->CHECK on preset, else ->ENDED if movable=0.
REQ-014 SHALL transition from CHECK: ->WON if any cell code >= WIN_CODE, else ->ENDED if movable=0, else ->WAIT_PRESS; WAIT_PRESS->PENDING on the move_dir pulse.
REQ-015 SHALL transition from PENDING: ->ENDED if movable=0; else ->INIT_2 if (sent & board_done)!=0; else ->CHECK when the watchdog reaches PEND_MAX (counter cleared on PENDING entry).
REQ-016 SHALL hold ENDED and WON until reset, except as in REQ-022.
REQ-017 SHALL assert preset = gen_done in INIT_1 or INIT_2; preset_loc = gen_loc when gen_done, else 0; preset_val = 1 if gen_low, else 2.
REQ-018 SHALL set won in the cycle after entering WON and clear it only on reset or restart.

Reset
REQ-019 SHALL, when rst=0 at a clk edge, force state=IDLE and clear the tick counter, s1, s2, sent, watchdog, move_dir, won and clear_board to 0.
REQ-020 SHALL give reset priority over every event, including mid-PENDING and a concurrent move_dir pulse.

Configuration
REQ-021 SHALL compile auto-restart logic only when the macro GAME_AUTO_RESTART_EN is defined.
REQ-022 SHALL, with GAME_AUTO_RESTART_EN defined, in ENDED or WON on any qualified rising button edge (movable gating ignored), pulse clear_board for one cycle, clear won and go to IDLE; without it, tie clear_board to 0 and keep ENDED and WON terminal.

Verification
REQ-023 SHALL cover: rst low 3 cycles, then high, gen_done=1, gen_loc=5 -> states 0,1,2,3,6; preset high in states 1 and 3; preset_loc=5.
REQ-024 SHALL cover: TICK_DIV=4, WAIT_PRESS, movable=3, button 0001 held -> one move_dir=0001 pulse; PENDING; board_done=0001 -> INIT_2.
REQ-025 SHALL cover: buttons 1010 rise together, movable=2 -> move_dir=1000 only; movable=1 with button 0010 -> no pulse.
REQ-026 SHALL cover: PEND_MAX=8, board_done held 0 -> return to CHECK 9 cycles after PENDING entry; movable=0 in PENDING -> ENDED next cycle.
REQ-027 SHALL cover: a cell code of 11 at CHECK -> WON, won=1; with GAME_AUTO_RESTART_EN, a button edge -> clear_board pulse, state 0, won=0.
